// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : RV32I program counter, imem fetch handshake, misaligned-target halt
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nextPCSrc,
  input  logic [31:0] alu_res,
  input  logic        stall,
  input  logic        imem_rdy,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instret;
  logic [31:0] r_fault_addr;
  logic        r_misaligned;
  logic        w_retire;
  logic        w_fault;
  logic        w_advance;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  // stall outranks imem_rdy, so a stalled cycle never reaches the fault check
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_fault     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_retire  = imem_rdy && !stall;
        w_fault   = w_retire && nextPCSrc && (alu_res[1:0] != 2'b00);
        w_advance = w_retire && !w_fault;
        if (w_fault) w_state_nxt = ST_HALT;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_instret    <= 32'd0;
      r_fault_addr <= 32'd0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_pc      <= nextPCSrc ? alu_res : w_pc_plus4;
        r_instret <= r_instret + 32'd1;
      end
      if (w_fault) begin
        r_fault_addr <= alu_res;
        r_misaligned <= 1'b1;
      end
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign imem_req   = (r_state == ST_FETCH);
  assign halted     = (r_state == ST_HALT);
  assign misaligned = r_misaligned;
  assign fault_addr = r_fault_addr;
  assign instret    = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : directed scoreboard bench for pc_fetch_unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_w = 1'b1;
  logic        nextPCSrc = 1'b0;
  logic [31:0] alu_res = 32'd0;
  logic        stall = 1'b0;
  logic        imem_rdy = 1'b0;

  logic [31:0] pc, pc_plus4, fault_addr, instret;
  logic        imem_req, halted, misaligned;
  logic [31:0] pc_w, pc_plus4_w, fault_addr_w, instret_w;
  logic        imem_req_w, halted_w, misaligned_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .nextPCSrc(nextPCSrc), .alu_res(alu_res),
    .stall(stall), .imem_rdy(imem_rdy), .pc(pc), .pc_plus4(pc_plus4),
    .imem_req(imem_req), .halted(halted), .misaligned(misaligned),
    .fault_addr(fault_addr), .instret(instret)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .nextPCSrc(nextPCSrc), .alu_res(alu_res),
    .stall(stall), .imem_rdy(imem_rdy), .pc(pc_w), .pc_plus4(pc_plus4_w),
    .imem_req(imem_req_w), .halted(halted_w), .misaligned(misaligned_w),
    .fault_addr(fault_addr_w), .instret(instret_w)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic [31:0] inst;
    logic [31:0] fa;
    logic        req;
    logic        hlt;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  // reference model: 0 boot, 1 fetch, 2 halt
  int          m_st;
  logic [31:0] m_pc, m_inst, m_fa;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    m_st = 0; m_pc = rpc; m_inst = 0; m_fa = 0; m_mis = 1'b0;
  endtask

  task automatic check_reset(input logic [31:0] rpc);
    chk("rst_pc", pc, rpc);
    chk("rst_pc_plus4", pc_plus4, rpc + 32'd4);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_instret", instret, 32'd0);
  endtask

  task automatic step(input string tag, input logic src, input logic [31:0] alu,
                      input logic stl, input logic rdy);
    exp_t e;
    exp_t o;
    @(negedge clk);
    nextPCSrc = src; alu_res = alu; stall = stl; imem_rdy = rdy;
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && rdy && !stl) begin
      if (src && alu[1:0] != 2'b00) begin
        m_fa = alu; m_mis = 1'b1; m_st = 2;
      end else begin
        m_pc   = src ? alu : m_pc + 32'd4;
        m_inst = m_inst + 32'd1;
      end
    end
    e.pc = m_pc; e.pp4 = m_pc + 32'd4; e.inst = m_inst; e.fa = m_fa;
    e.req = (m_st == 1); e.hlt = (m_st == 2); e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 1) else begin
      failures++;
      $error("FAIL %s_sb_depth observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      o = sb.pop_front();
      chk({tag, "_pc"}, pc, o.pc);
      chk({tag, "_pc_plus4"}, pc_plus4, o.pp4);
      chk({tag, "_instret"}, instret, o.inst);
      chk({tag, "_fault_addr"}, fault_addr, o.fa);
      chk({tag, "_imem_req"}, {31'd0, imem_req}, {31'd0, o.req});
      chk({tag, "_halted"}, {31'd0, halted}, {31'd0, o.hlt});
      chk({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, o.mis});
    end
  endtask

  initial begin
    model_reset(32'h100);
    repeat (2) @(posedge clk);
    #1;
    check_reset(32'h100);
    chk("wrap_rst_pc", pc_w, 32'hFFFF_FFFC);
    chk("wrap_rst_pc_plus4", pc_plus4_w, 32'h0000_0000);
    rst = 1'b0;

    // boot cycle then sequential fetch
    step("boot", 1'b0, 32'd0, 1'b0, 1'b1);
    step("seq1", 1'b0, 32'd0, 1'b0, 1'b1);
    step("seq2", 1'b0, 32'd0, 1'b0, 1'b1);
    step("taken200", 1'b1, 32'h200, 1'b0, 1'b1);
    step("seq3", 1'b0, 32'h200, 1'b0, 1'b1);
    // stall beats ready, then not-ready
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step("notrdy", 1'b0, 32'd0, 1'b0, 1'b0);
    step("resume", 1'b0, 32'd0, 1'b0, 1'b1);
    step("mis_untaken", 1'b0, 32'h3, 1'b0, 1'b1);
    step("mis_stalled", 1'b1, 32'h202, 1'b1, 1'b1);
    step("taken40", 1'b1, 32'h40, 1'b0, 1'b1);
    step("fault", 1'b1, 32'h202, 1'b0, 1'b1);
    step("halt_seq", 1'b0, 32'd0, 1'b0, 1'b1);
    step("halt_taken", 1'b1, 32'h300, 1'b0, 1'b1);
    step("halt_mis", 1'b1, 32'h305, 1'b0, 1'b1);

    // only reset leaves HALT
    rst = 1'b1;
    #1;
    check_reset(32'h100);
    rst = 1'b0;
    model_reset(32'h100);
    step("reboot", 1'b0, 32'd0, 1'b0, 1'b1);
    step("reseq1", 1'b0, 32'd0, 1'b0, 1'b1);
    step("reseq2", 1'b1, 32'h80, 1'b0, 1'b1);

    // asynchronous reset in the middle of a FETCH cycle
    #1;
    rst = 1'b1;
    #1;
    check_reset(32'h100);
    #1;
    rst = 1'b0;
    model_reset(32'h100);
    step("post_async_boot", 1'b0, 32'd0, 1'b0, 1'b1);
    step("post_async_seq", 1'b0, 32'd0, 1'b0, 1'b1);

    // pc_plus4 / pc wrap on the second instance
    @(negedge clk);
    nextPCSrc = 1'b0; stall = 1'b0; imem_rdy = 1'b1;
    rst_w = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_boot_req", {31'd0, imem_req_w}, 32'd1);
    chk("wrap_boot_pc", pc_w, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap_pc", pc_w, 32'h0000_0000);
    chk("wrap_pc_plus4", pc_plus4_w, 32'h0000_0004);
    chk("wrap_instret", instret_w, 32'd1);
    chk("wrap_halted", {31'd0, halted_w}, 32'd0);
    chk("wrap_misaligned", {31'd0, misaligned_w}, 32'd0);
    chk("wrap_fault_addr", fault_addr_w, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
